// File: rtl/scan_pkg.sv
// Shared definitions for the frame scan address generator: scan-order
// encodings, FSM state constants and the default frame geometry.
package scan_pkg;

    typedef enum logic [1:0] {
        SCAN_LR  = 2'd0,
        SCAN_UD  = 2'd1,
        SCAN_TTL = 2'd2,
        SCAN_TTR = 2'd3
    } scan_mode_e;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    localparam int DEF_IMG_W = 150;
    localparam int DEF_IMG_H = 150;

endpackage

// File: rtl/scan_diag_step.sv
// Next-position step for the diagonal scans: moves one pixel up the current
// diagonal, or restarts at the head of the next diagonal after a line end.
module scan_diag_step
    import scan_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int RC_W  = 8,
    parameter int LN_W  = 9
) (
    input  logic            ttr_i,
    input  logic [RC_W-1:0] row_i,
    input  logic [RC_W-1:0] col_i,
    input  logic [LN_W-1:0] line_i,
    input  logic            line_end_i,
    output logic [RC_W-1:0] row_o,
    output logic [RC_W-1:0] col_o,
    output logic [LN_W-1:0] line_o,
    output logic            line_end_o
);

    localparam logic [RC_W-1:0] LAST_COL = RC_W'(IMG_W - 1);
    localparam logic [LN_W-1:0] LAST_ROW_K = LN_W'(IMG_H - 1);

    logic [LN_W-1:0] k_nxt;
    logic [LN_W-1:0] off;

    always_comb begin
        k_nxt  = line_i + LN_W'(1);
        off    = '0;
        line_o = line_i;
        if (line_end_i) begin
            // Next diagonal starts on the bottom-most row it touches; off is
            // how far that head sits from the scan's starting column.
            line_o = k_nxt;
            if (k_nxt > LAST_ROW_K) begin
                row_o = RC_W'(IMG_H - 1);
                off   = k_nxt - LAST_ROW_K;
            end else begin
                row_o = RC_W'(k_nxt);
            end
            col_o = ttr_i ? (LAST_COL - RC_W'(off)) : RC_W'(off);
        end else begin
            row_o = row_i - RC_W'(1);
            col_o = ttr_i ? (col_i - RC_W'(1)) : (col_i + RC_W'(1));
        end
        line_end_o = (row_o == '0) || (ttr_i ? (col_o == '0) : (col_o == LAST_COL));
    end

endmodule

// File: rtl/scan_addr_gen.sv
// Raster/diagonal address generator for an IMG_W x IMG_H row-major frame;
// emits one address per valid/ready handshake with line and frame markers.
module scan_addr_gen
    import scan_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H),
    parameter int RC_W   = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H)
) (
    input  logic              clk,
    input  logic              resetIn,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] addr,
    output logic [RC_W-1:0]   row,
    output logic [RC_W-1:0]   col,
    output logic              line_end,
    output logic              frame_end,
    output logic              busy,
    output logic              done
);

    localparam int LN_W = $clog2(IMG_W + IMG_H);
    localparam logic [RC_W-1:0] LAST_COL = RC_W'(IMG_W - 1);
    localparam logic [RC_W-1:0] LAST_ROW = RC_W'(IMG_H - 1);

    state_t            state_q, state_d;
    scan_mode_e        mode_q, mode_d;
    logic [RC_W-1:0]   row_q, row_d, col_q, col_d;
    logic [LN_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d, le_q, le_d, fe_q, fe_d, done_q, done_d;
    logic              hs;

    logic [RC_W-1:0]   dg_row, dg_col;
    logic [LN_W-1:0]   dg_line;
    logic              dg_le;

    assign hs = valid_q & addr_ready;

    scan_diag_step #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .RC_W  (RC_W),
        .LN_W  (LN_W)
    ) u_diag (
        .ttr_i      (mode_q == SCAN_TTR),
        .row_i      (row_q),
        .col_i      (col_q),
        .line_i     (line_q),
        .line_end_i (le_q),
        .row_o      (dg_row),
        .col_o      (dg_col),
        .line_o     (dg_line),
        .line_end_o (dg_le)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        row_d   = row_q;
        col_d   = col_q;
        line_d  = line_q;
        valid_d = valid_q;
        le_d    = le_q;
        fe_d    = fe_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = scan_mode_e'(mode);
                    row_d   = '0;
                    line_d  = '0;
                    col_d   = (scan_mode_e'(mode) == SCAN_TTR) ? LAST_COL : '0;
                    valid_d = 1'b1;
                    // Diagonal scans open with a single-pixel line.
                    le_d    = mode[1];
                    fe_d    = 1'b0;
                end
            end
            default: begin
                if (hs) begin
                    if (fe_q) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        le_d    = 1'b0;
                        fe_d    = 1'b0;
                        row_d   = '0;
                        col_d   = '0;
                        line_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        case (mode_q)
                            SCAN_LR: begin
                                if (col_q == LAST_COL) begin
                                    col_d  = '0;
                                    row_d  = row_q + RC_W'(1);
                                    line_d = line_q + LN_W'(1);
                                end else begin
                                    col_d = col_q + RC_W'(1);
                                end
                                le_d = (col_d == LAST_COL);
                            end
                            SCAN_UD: begin
                                if (row_q == LAST_ROW) begin
                                    row_d  = '0;
                                    col_d  = col_q + RC_W'(1);
                                    line_d = line_q + LN_W'(1);
                                end else begin
                                    row_d = row_q + RC_W'(1);
                                end
                                le_d = (row_d == LAST_ROW);
                            end
                            default: begin
                                row_d  = dg_row;
                                col_d  = dg_col;
                                line_d = dg_line;
                                le_d   = dg_le;
                            end
                        endcase
                        fe_d = (row_d == LAST_ROW) &&
                               ((mode_q == SCAN_TTR) ? (col_d == '0) : (col_d == LAST_COL));
                    end
                end
            end
        endcase
    end

    // Address is registered alongside row/col so it never lags them.
    assign addr_d = ADDR_W'(row_d) * ADDR_W'(IMG_W) + ADDR_W'(col_d);

    always_ff @(posedge clk or posedge resetIn) begin
        if (resetIn) begin
            state_q <= ST_IDLE;
            mode_q  <= SCAN_LR;
            row_q   <= '0;
            col_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            le_q    <= 1'b0;
            fe_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            row_q   <= row_d;
            col_q   <= col_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            le_q    <= le_d;
            fe_q    <= fe_d;
            done_q  <= done_d;
        end
    end

    assign addr_valid = valid_q;
    assign addr       = addr_q;
    assign row        = row_q;
    assign col        = col_q;
    assign line_end   = le_q;
    assign frame_end  = fe_q;
    assign busy       = (state_q == ST_RUN);
    assign done       = done_q;

endmodule

// File: tb/tb_scan_addr_gen.sv
// Self-checking bench for scan_addr_gen: a 4x3 instance for the scan-order
// tables and randomized backpressure, and a default 150x150 instance.
module tb_scan_addr_gen;

    localparam int SW = 4;
    localparam int SH = 3;
    localparam int DW = 150;
    localparam int DH = 150;

    logic clk = 1'b0;
    logic resetIn;
    always #5 clk = ~clk;

    logic       s_start, s_ready;
    logic [1:0] s_mode;
    logic       s_valid, s_le, s_fe, s_busy, s_done;
    logic [3:0] s_addr;
    logic [1:0] s_row, s_col;

    logic        d_start, d_ready;
    logic [1:0]  d_mode;
    logic        d_valid, d_le, d_fe, d_busy, d_done;
    logic [14:0] d_addr;
    logic [7:0]  d_row, d_col;

    scan_addr_gen #(.IMG_W(SW), .IMG_H(SH)) dut_s (
        .clk(clk), .resetIn(resetIn), .start(s_start), .mode(s_mode),
        .addr_ready(s_ready), .addr_valid(s_valid), .addr(s_addr),
        .row(s_row), .col(s_col), .line_end(s_le), .frame_end(s_fe),
        .busy(s_busy), .done(s_done)
    );

    scan_addr_gen dut_d (
        .clk(clk), .resetIn(resetIn), .start(d_start), .mode(d_mode),
        .addr_ready(d_ready), .addr_valid(d_valid), .addr(d_addr),
        .row(d_row), .col(d_col), .line_end(d_le), .frame_end(d_fe),
        .busy(d_busy), .done(d_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each scan order is a list of lines, each line a list
    // of pixels; line_end marks the last pixel of a line, frame_end the last.
    typedef struct packed {
        int a;
        bit le;
        bit fe;
    } beat_t;

    beat_t exp_q[$];

    function automatic void build(input int w, input int h, input int m);
        beat_t b;
        int    cells[$];
        exp_q.delete();
        if (m == 0) begin
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++) begin
                    b = '{a: r * w + c, le: (c == w - 1), fe: 1'b0};
                    exp_q.push_back(b);
                end
        end else if (m == 1) begin
            for (int c = 0; c < w; c++)
                for (int r = 0; r < h; r++) begin
                    b = '{a: r * w + c, le: (r == h - 1), fe: 1'b0};
                    exp_q.push_back(b);
                end
        end else begin
            for (int k = 0; k <= w + h - 2; k++) begin
                cells.delete();
                for (int r = h - 1; r >= 0; r--) begin
                    int d;
                    d = k - r;
                    if (d >= 0 && d < w)
                        cells.push_back(r * w + ((m == 2) ? d : (w - 1 - d)));
                end
                foreach (cells[j]) begin
                    b = '{a: cells[j], le: (j == cells.size() - 1), fe: 1'b0};
                    exp_q.push_back(b);
                end
            end
        end
        exp_q[exp_q.size() - 1].fe = 1'b1;
    endfunction

    typedef struct packed {
        logic [1:0]  mode;
        logic [47:0] addrs;
        logic [11:0] le;
    } vec_t;

    vec_t vecs[4];
    vec_t cur;

    task automatic run_random(input int m);
        int   idx, cyc, ea;
        logic pstall;
        logic [3:0] pa;
        logic [1:0] pr, pc;
        logic ple, pfe;
        build(SW, SH, m);
        s_mode  = 2'(m);
        s_start = 1'b1;
        s_ready = 1'($urandom_range(0, 1));
        tick();
        s_start = 1'b0;
        idx = 0; cyc = 0; pstall = 1'b0;
        pa = '0; pr = '0; pc = '0; ple = 1'b0; pfe = 1'b0;
        while (idx < exp_q.size() && cyc < 500) begin
            chk("rnd_valid", int'(s_valid), 1);
            if (pstall) begin
                chk("stall_addr", int'(s_addr), int'(pa));
                chk("stall_rowcol", int'({s_row, s_col}), int'({pr, pc}));
                chk("stall_marks", int'({s_le, s_fe}), int'({ple, pfe}));
            end
            ea = exp_q[idx].a;
            chk("rnd_addr", int'(s_addr), ea);
            chk("rnd_row", int'(s_row), ea / SW);
            chk("rnd_col", int'(s_col), ea % SW);
            chk("rnd_line_end", int'(s_le), int'(exp_q[idx].le));
            chk("rnd_frame_end", int'(s_fe), int'(exp_q[idx].fe));
            pa = s_addr; pr = s_row; pc = s_col; ple = s_le; pfe = s_fe;
            s_ready = 1'($urandom_range(0, 1));
            s_start = 1'($urandom_range(0, 1));
            s_mode  = 2'($urandom_range(0, 3));
            pstall  = !s_ready;
            if (s_ready) idx++;
            tick();
            cyc++;
        end
        chk("rnd_beats", idx, exp_q.size());
        s_start = 1'b0;
        chk("rnd_done", int'(s_done), 1);
        chk("rnd_valid_off", int'(s_valid), 0);
        tick();
        chk("rnd_done_once", int'(s_done), 0);
        chk("rnd_stay_idle", int'(s_busy), 0);
    endtask

    initial begin
        int r, c;
        resetIn = 1'b1;
        s_start = 1'b0; s_ready = 1'b0; s_mode = 2'd0;
        d_start = 1'b0; d_ready = 1'b0; d_mode = 2'd0;

        // Nibble i of addrs is beat i; bit i of le is line_end on beat i.
        vecs[0] = '{mode: 2'd0, addrs: 48'hBA9876543210, le: 12'h888};
        vecs[1] = '{mode: 2'd1, addrs: 48'hB73A62951840, le: 12'h924};
        vecs[2] = '{mode: 2'd2, addrs: 48'hB7A369258140, le: 12'hD25};
        vecs[3] = '{mode: 2'd3, addrs: 48'h84905A16B273, le: 12'hD25};

        tick();
        tick();
        chk("rst_valid", int'({s_valid, d_valid}), 0);
        chk("rst_addr", int'(s_addr) + int'(d_addr), 0);
        chk("rst_rowcol", int'({s_row, s_col, d_row, d_col}), 0);
        chk("rst_flags", int'({s_le, s_fe, s_busy, s_done, d_le, d_fe, d_busy, d_done}), 0);
        resetIn = 1'b0;
        tick();
        chk("idle_valid", int'(s_valid), 0);

        for (int v = 0; v < 4; v++) begin
            cur = vecs[v];
            s_mode  = cur.mode;
            s_ready = 1'b1;
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
            s_mode  = ~cur.mode;
            for (int i = 0; i < 12; i++) begin
                chk("tbl_valid", int'(s_valid), 1);
                chk("tbl_busy", int'(s_busy), 1);
                chk("tbl_addr", int'(s_addr), int'(cur.addrs[4*i +: 4]));
                chk("tbl_row", int'(s_row), int'(cur.addrs[4*i +: 4]) / SW);
                chk("tbl_col", int'(s_col), int'(cur.addrs[4*i +: 4]) % SW);
                chk("tbl_line_end", int'(s_le), int'(cur.le[i]));
                chk("tbl_frame_end", int'(s_fe), (i == 11) ? 1 : 0);
                chk("tbl_done_low", int'(s_done), 0);
                if (i == 11) s_start = 1'b1;
                tick();
            end
            s_start = 1'b0;
            chk("tbl_done", int'(s_done), 1);
            chk("tbl_end_valid", int'(s_valid), 0);
            chk("tbl_end_busy", int'(s_busy), 0);
            tick();
            chk("tbl_done_pulse", int'(s_done), 0);
            chk("tbl_start_ignored", int'(s_valid), 0);
        end

        for (int n = 0; n < 8; n++)
            run_random(n % 4);

        d_mode  = 2'd1;
        d_ready = 1'b1;
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            chk("ud_pre_addr", int'(d_addr), (i % DH) * DW + (i / DH));
            tick();
        end
        resetIn = 1'b1;
        #1;
        chk("abort_valid", int'(d_valid), 0);
        chk("abort_addr", int'(d_addr), 0);
        chk("abort_rowcol", int'({d_row, d_col}), 0);
        chk("abort_flags", int'({d_le, d_fe, d_busy, d_done}), 0);
        tick();
        chk("abort_no_done", int'(d_done), 0);
        resetIn = 1'b0;
        tick();
        chk("abort_no_done2", int'(d_done), 0);
        chk("abort_idle", int'(d_valid), 0);

        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        for (int i = 0; i < DW * DH; i++) begin
            r = i % DH;
            c = i / DH;
            chk("ud_valid", int'(d_valid), 1);
            chk("ud_addr", int'(d_addr), r * DW + c);
            chk("ud_rowcol", int'(d_row) * 256 + int'(d_col), r * 256 + c);
            chk("ud_line_end", int'(d_le), (r == DH - 1) ? 1 : 0);
            chk("ud_frame_end", int'(d_fe), (i == DW * DH - 1) ? 1 : 0);
            tick();
        end
        chk("ud_done", int'(d_done), 1);
        chk("ud_valid_off", int'(d_valid), 0);
        tick();
        chk("ud_done_pulse", int'(d_done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_addr_gen.md
Name: scan_addr_gen

Overview:
Parametrised raster/diagonal address generator for an IMG_W x IMG_H frame stored row-major (addr = row*IMG_W + col). It replaces the fixed 150x150 counter. It walks the frame in one of four scan orders and emits one address per valid/ready handshake to the pixel-fetch stage. It flags line and frame boundaries so the downstream edge detector can reset per line.

Parameters:
IMG_W, 150, frame width in pixels (>= 2)
IMG_H, 150, frame height in pixels (>= 2)
ADDR_W, $clog2(IMG_W*IMG_H), address width (15 at defaults)
RC_W, $clog2(max(IMG_W,IMG_H)), row/col counter width (8 at defaults)

Ports:
clk  in  1  clock, rising edge
resetIn  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a frame scan; sampled only in IDLE
mode  in  2  scan order, latched on accepted start: 0 LR, 1 UD, 2 TTL, 3 TTR
addr_ready  in  1  downstream accepts current address
addr_valid  out  1  addr/row/col/line_end/frame_end are valid
addr  out  ADDR_W  row*IMG_W + col
row  out  RC_W  current row index (0-based)
col  out  RC_W  current column index (0-based)
line_end  out  1  current address is the last of its line; qualified by addr_valid
frame_end  out  1  current address is the last of the frame; qualified by addr_valid
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; row, col, line counter and latched mode all 0.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on start: first address presented with addr_valid=1 on the next cycle (latency 1).
  - RUN -> IDLE on the handshake (addr_valid & addr_ready) of the frame_end beat; done=1 the following cycle only.
- In RUN, start and mode changes are ignored.
- Outputs hold stable while addr_valid & !addr_ready. They advance exactly once per handshake. No bubbles: addr_valid stays high from first beat through frame_end beat.
- Every mode emits exactly IMG_W*IMG_H addresses, each once.
- LR: lines are rows 0..IMG_H-1, col 0..IMG_W-1 ascending. line_end at col==IMG_W-1.
- UD: lines are columns 0..IMG_W-1, row 0..IMG_H-1 ascending. line_end at row==IMG_H-1.
- TTL (anti-diagonals): line k = 0..IMG_W+IMG_H-2.
  - Start row = min(k, IMG_H-1), col = k-row.
  - Step row-1, col+1.
  - line_end when row==0 or col==IMG_W-1.
- TTR (diagonals): line k = 0..IMG_W+IMG_H-2.
  - Start row = min(k, IMG_H-1), col = IMG_W-1-(k-row).
  - Step row-1, col-1.
  - line_end when row==0 or col==0.
- Single-pixel lines (first/last diagonal) assert line_end on their only beat.
- frame_end is asserted with line_end on the last beat: LR (H-1,W-1); UD (H-1,W-1); TTL (H-1,W-1); TTR (H-1,0).
- addr is registered and must equal row*IMG_W+col on every valid beat. It is maintained incrementally (+1, +IMG_W, -IMG_W+1, -IMG_W-1, line restarts) or via one registered multiply; either way it carries no extra latency. No overflow: max addr = IMG_W*IMG_H-1.
- Reset mid-scan aborts immediately. done is not pulsed; a new start is required.
- start coincident with the final handshake is ignored; a new start is accepted only in IDLE.

Decomposition:
- Shared package scan_pkg: mode encodings SCAN_LR/SCAN_UD/SCAN_TTL/SCAN_TTR, FSM state typedef, default IMG_W/IMG_H constants.
- One natural sub-module: scan_diag_step, which computes the next (row, col, line_end) for TTL/TTR from the current position and line index.
- LR/UD stepping stays inline.

Test Plan:
- IMG_W=4, IMG_H=3, LR, ready=1 -> addr 0..11 on 12 consecutive cycles; line_end at 3, 7, 11; frame_end at 11; done pulse one cycle later.
- UD, same params -> 0,4,8,1,5,9,2,6,10,3,7,11; line_end at 8, 9, 10, 11.
- TTL, same params -> 0 | 4,1 | 8,5,2 | 9,6,3 | 10,7 | 11, where "|" marks line_end; frame_end at 11.
- TTR, same params -> 3 | 7,2 | 11,6,1 | 10,5,0 | 9,4 | 8, where "|" marks line_end; frame_end at 8.
- Backpressure with random addr_ready (~50%) in LR and TTL -> identical address sequence to ready=1; outputs stable during stall cycles; start and mode toggles during RUN have no effect.
- Defaults 150x150 UD: assert resetIn after 200 beats -> all outputs 0 and no done pulse; restart yields first address 0, then 150; a full run ends at addr 22499 with frame_end after 22500 beats.
